step_sequencer: RTL
===================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 SHALL have parameter STEPS, default 16, meaning the number of steps per pattern (power of two).
REQ-002 SHALL have parameter TRACKS, default 4, meaning the number of trigger tracks (one per sample slot).
REQ-003 SHALL have parameter TRIG_LEN, default 4, meaning the trigger pulse width in clk200 cycles.
REQ-004 SHALL have parameter MIN_PERIOD, default 8, meaning the minimum step period in cycles (MIN_PERIOD > TRIG_LEN).
REQ-005 SHALL have ports: clk200  in  1  system clock, all logic on posedge; reset  in  1  synchronous, active-high.
REQ-006 SHALL have port run  in  1  level; 1 = play, 0 = stop.
REQ-007 SHALL have port step_period  in  28  clk200 cycles per step.
REQ-008 SHALL have ports edit_track  in  2 and edit_step  in  4, which address a pattern cell.
REQ-009 SHALL have port edit_toggle  in  1, a one-cycle pulse that inverts the addressed cell.
REQ-010 SHALL have port clear  in  1, a one-cycle pulse that zeroes the whole pattern.
REQ-011 SHALL have port mute  in  4, a per-track mask; 1 = suppress the trigger.
REQ-012 SHALL have port load_req  in  1, a one-cycle pulse requesting a sample reload.
REQ-013 SHALL have port trigger  out  4, per-track pulses to the sampler.
REQ-014 SHALL have port start_load  out  1, a one-cycle load pulse to the sampler.
REQ-015 SHALL have ports: step_index  out  4  current step; beat  out  1  one-cycle pulse at each step start; running  out  1  state==RUNNING.

Function
REQ-016 SHALL implement FSM states STOPPED and RUNNING.
REQ-017 SHALL move STOPPED->RUNNING on the cycle after run=1 is sampled.
  - On entry: step_index=0, tick counter=0, period latched.
REQ-018 SHALL move RUNNING->STOPPED on the cycle after run=0 is sampled.
  - On that cycle: trigger=0 immediately, step_index=0, tick counter=0.
REQ-019 SHALL define a step start as RUNNING entry or a step advance.
  - Each step start: beat=1 for one cycle.
  - Each step start: trigger[t]=pattern[t][step_index] & ~mute[t], held exactly TRIG_LEN cycles.
REQ-020 SHALL advance the step (step_index+1, tick=0) on the cycle after tick == latched_period-1.
  - Otherwise the tick counter increments.
  - Consecutive step starts are exactly latched_period cycles apart.
REQ-021 SHALL wrap step_index from STEPS-1 to 0 with no gap or extra cycle.
REQ-022 SHALL latch step_period only at RUNNING entry and at each step advance; mid-step changes take effect at the next step.
REQ-023 SHALL clamp the latched period to MIN_PERIOD when step_period < MIN_PERIOD (including 0).
REQ-024 SHALL sample pattern and mute at the step-start cycle.
  - An edit_toggle on the same cell in the same cycle does not affect that trigger; it applies on the next visit.
REQ-025 SHALL give clear priority over edit_toggle when both are asserted in the same cycle.
REQ-026 SHALL accept edits in both states.
REQ-027 SHALL emit start_load one cycle after load_req only while STOPPED; load_req while RUNNING is dropped, not queued.
REQ-028 SHALL keep trigger, beat and start_load registered and glitch-free.

Reset
REQ-029 SHALL, while reset=1, force state=STOPPED, pattern all 0, step_index=0, tick=0, trigger=0, beat=0, start_load=0, running=0.
REQ-030 SHALL let reset asserted mid-step or mid-pulse terminate any trigger on the next edge; after release, run must be re-sampled before RUNNING.

Verification
REQ-031 SHALL cover: toggle track0 steps 0 and 4, period=10, run=1 -> trigger[0] rises at T, T+40, T+160; each high 4 cycles; beat every 10 cycles.
REQ-032 SHALL cover: period=3 (< MIN_PERIOD) -> step starts 8 cycles apart.
REQ-033 SHALL cover: change period 10->20 mid-step 2 -> step 3 still starts 10 cycles after step 2; step 4 starts 20 cycles after step 3.
REQ-034 SHALL cover: mute=0001 with all cells set -> trigger=1110 at every step; run=0 mid-pulse -> trigger=0 next cycle.
REQ-035 SHALL cover: load_req while RUNNING -> no start_load; load_req while STOPPED -> start_load high exactly 1 cycle.
REQ-036 SHALL cover: clear and edit_toggle in the same cycle -> pattern all 0; reset during RUNNING -> all outputs 0 and running=0 next cycle.

Source files
------------

// File: rtl/step_sequencer_if.sv
// Sequencer control/edit bus and sampler-facing trigger outputs.
// master drives controls and edits; slave is the sequencer.
interface step_sequencer_if #(
  parameter int STEPS  = 16,
  parameter int TRACKS = 4
);
  logic                      run;
  logic [27:0]               step_period;
  logic [$clog2(TRACKS)-1:0] edit_track;
  logic [$clog2(STEPS)-1:0]  edit_step;
  logic                      edit_toggle;
  logic                      clear;
  logic [TRACKS-1:0]         mute;
  logic                      load_req;
  logic [TRACKS-1:0]         trigger;
  logic                      start_load;
  logic [$clog2(STEPS)-1:0]  step_index;
  logic                      beat;
  logic                      running;

  modport master (
    output run, step_period, edit_track, edit_step,
    output edit_toggle, clear, mute, load_req,
    input  trigger, start_load, step_index, beat, running
  );

  modport slave (
    input  run, step_period, edit_track, edit_step,
    input  edit_toggle, clear, mute, load_req,
    output trigger, start_load, step_index, beat, running
  );
endinterface

// File: rtl/step_sequencer.sv
// Pattern step sequencer: per-track trigger pulses at each step start.
// Period latched per step, clamped to MIN_PERIOD; loads only while stopped.
module step_sequencer #(
  parameter int STEPS      = 16,
  parameter int TRACKS     = 4,
  parameter int TRIG_LEN   = 4,
  parameter int MIN_PERIOD = 8
) (
  input logic             clk200,
  input logic             reset,
  step_sequencer_if.slave bus
);
  localparam int SW = $clog2(STEPS);

  typedef enum logic {STOPPED, RUNNING} state_t;

  state_t                        state, state_n;
  logic [TRACKS-1:0][STEPS-1:0]  pattern;
  logic [SW-1:0]                 step_q, step_n;
  logic [27:0]                   tick, period_q, period_in;
  logic [TRACKS-1:0]             trig_q, cells;
  logic                          start, advance;
  logic                          beat_q, load_q;

  assign bus.trigger    = trig_q;
  assign bus.beat       = beat_q;
  assign bus.start_load = load_q;
  assign bus.step_index = step_q;
  assign bus.running    = (state == RUNNING);

  // Clamp the requested period before it is latched.
  always_comb begin
    period_in = bus.step_period;
    if (bus.step_period < 28'(MIN_PERIOD))
      period_in = 28'(MIN_PERIOD);
  end

  // Next state, step-start detection and the cells due at that start.
  always_comb begin
    state_n = state;
    start   = 1'b0;
    advance = 1'b0;
    cells   = '0;
    unique case (state)
      STOPPED: begin
        if (bus.run) begin
          state_n = RUNNING;
          start   = 1'b1;
        end
      end
      RUNNING: begin
        if (!bus.run) begin
          state_n = STOPPED;
        end else if (tick == period_q - 28'd1) begin
          start   = 1'b1;
          advance = 1'b1;
        end
      end
    endcase
    step_n = advance ? step_q + 1'b1 : '0;
    for (int t = 0; t < TRACKS; t++)
      cells[t] = pattern[t][step_n] & ~bus.mute[t];
  end

  // State register.
  always_ff @(posedge clk200) begin
    if (reset) state <= STOPPED;
    else       state <= state_n;
  end

  // Step counter, tick counter, period latch and registered pulses.
  always_ff @(posedge clk200) begin
    if (reset) begin
      step_q   <= '0;
      tick     <= '0;
      period_q <= '0;
      trig_q   <= '0;
      beat_q   <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      beat_q <= start;
      load_q <= bus.load_req && (state == STOPPED);
      if (start) begin
        step_q   <= step_n;
        tick     <= '0;
        period_q <= period_in;
        trig_q   <= cells;
      end else if (state == RUNNING && state_n == STOPPED) begin
        step_q <= '0;
        tick   <= '0;
        trig_q <= '0;
      end else if (state == RUNNING) begin
        tick <= tick + 28'd1;
        if (tick == 28'(TRIG_LEN - 1))
          trig_q <= '0;
      end
    end
  end

  // Pattern memory; clear wins over a simultaneous toggle.
  always_ff @(posedge clk200) begin
    if (reset || bus.clear)
      pattern <= '0;
    else if (bus.edit_toggle)
      pattern[bus.edit_track][bus.edit_step] <=
        ~pattern[bus.edit_track][bus.edit_step];
  end
endmodule
